if_req_arbiter: RTL and testbench

IF_REQ_ARBITER -- requirements
Module: if_req_arbiter

---
 rtl/if_req_arbiter.sv | 132 +++++++++++++
 tb/tb_if_req_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_req_arbiter.sv
// Round-robin arbiter granting one interface-controller requester at a time
// access to the rename unit, holding the grant until the owner signals done.
module if_req_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH_OWN = $clog2(NUM_REQ),
  parameter int unsigned WIDTH_FTK = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             I_Req,
  input  logic [NUM_REQ*WIDTH_FTK-1:0]   I_FTk,
  output logic [NUM_REQ-1:0]             O_Grant,
  output logic [WIDTH_FTK-1:0]           O_FTk,
  output logic                           O_Req,
  input  logic                           I_Ack,
  input  logic                           I_Stall,
  input  logic                           I_Done,
  output logic [WIDTH_OWN-1:0]           O_Owner,
  output logic                           O_Busy
);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SEL,
    ARB_WAIT,
    ARB_HOLD
  } arb_state_e;

  arb_state_e           state_q;
  logic [WIDTH_OWN-1:0] r_ptr_q;
  logic [WIDTH_OWN-1:0] r_ptr_d;
  logic [WIDTH_OWN-1:0] r_owner_q;
  logic [WIDTH_OWN-1:0] sel_idx;
  logic                 sel_found;
  logic                 owner_req;
  logic [WIDTH_FTK-1:0] ftk_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      ftk_arr[i] = I_FTk[i*WIDTH_FTK +: WIDTH_FTK];
    end
  end

  // First active request at or after the pointer, wrapping around.
  always_comb begin
    int unsigned          k;
    logic [WIDTH_OWN-1:0] kk;
    sel_found = 1'b0;
    sel_idx   = '0;
    k         = 0;
    kk        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(r_ptr_q) + i;
      if (k >= NUM_REQ) begin
        k = k - NUM_REQ;
      end
      kk = WIDTH_OWN'(k);
      if (!sel_found && I_Req[kk]) begin
        sel_found = 1'b1;
        sel_idx   = kk;
      end
    end
  end

  always_comb begin
    r_ptr_d = (r_owner_q == WIDTH_OWN'(NUM_REQ - 1)) ? '0 : r_owner_q + WIDTH_OWN'(1);
  end

  assign owner_req = I_Req[r_owner_q];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      r_ptr_q   <= '0;
      r_owner_q <= '0;
      O_Grant   <= '0;
      O_Req     <= 1'b0;
      O_FTk     <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|I_Req) begin
            state_q <= ARB_SEL;
          end
        end
        ARB_SEL: begin
          if (sel_found) begin
            r_owner_q <= sel_idx;
            O_Grant   <= NUM_REQ'(1) << sel_idx;
            O_FTk     <= ftk_arr[sel_idx];
            O_Req     <= 1'b1;
            state_q   <= ARB_WAIT;
          end else begin
            state_q <= ARB_IDLE;
          end
        end
        ARB_WAIT: begin
          // Withdrawal outranks acknowledge; pointer is left where it was.
          if (!owner_req) begin
            O_Grant <= '0;
            O_Req   <= 1'b0;
            O_FTk   <= '0;
            state_q <= ARB_IDLE;
          end else if (I_Ack && !I_Stall) begin
            O_Req   <= 1'b0;
            state_q <= ARB_HOLD;
          end
        end
        ARB_HOLD: begin
          if (!owner_req) begin
            O_Grant <= '0;
            O_Req   <= 1'b0;
            O_FTk   <= '0;
            state_q <= ARB_IDLE;
          end else if (I_Done) begin
            O_Grant <= '0;
            O_FTk   <= '0;
            r_ptr_q <= r_ptr_d;
            state_q <= ARB_IDLE;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign O_Owner = r_owner_q;
  assign O_Busy  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_if_req_arbiter.sv
// Randomized scoreboard bench for if_req_arbiter against a transaction-level
// round-robin model.
module tb_if_req_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned FW = 8;
  localparam int unsigned OW = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      I_Req;
  logic [N*FW-1:0]   I_FTk;
  logic [N-1:0]      O_Grant;
  logic [FW-1:0]     O_FTk;
  logic              O_Req;
  logic              I_Ack;
  logic              I_Stall;
  logic              I_Done;
  logic [OW-1:0]     O_Owner;
  logic              O_Busy;

  if_req_arbiter #(.NUM_REQ(N), .WIDTH_OWN(OW), .WIDTH_FTK(FW)) dut (
    .clock   (clock),
    .reset   (reset),
    .I_Req   (I_Req),
    .I_FTk   (I_FTk),
    .O_Grant (O_Grant),
    .O_FTk   (O_FTk),
    .O_Req   (O_Req),
    .I_Ack   (I_Ack),
    .I_Stall (I_Stall),
    .I_Done  (I_Done),
    .O_Owner (O_Owner),
    .O_Busy  (O_Busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          owner;
    logic [FW-1:0] ftk;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   model_ptr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (p + i) % N;
      if (m[k]) return k;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    I_Req   = '0;
    I_Ack   = 1'b0;
    I_Stall = 1'b0;
    I_Done  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_ptr = 0;
    q.delete();
  endtask

  // Apply a request mask, expect the model's winner, wait for O_Req.
  task automatic start_txn(input logic [N-1:0] mask, output int own, output logic [N*FW-1:0] f,
                           output bit ok);
    exp_t e;
    int   cnt;
    f       = (N*FW)'($urandom);
    I_FTk   = f;
    own     = pick(mask, model_ptr);
    e.owner = own;
    e.ftk   = f[own*FW +: FW];
    q.push_back(e);
    I_Req = mask;
    cnt   = 0;
    do begin
      step();
      cnt++;
    end while (!O_Req && cnt < 10);
    chk("req_latency", 64'(cnt), 64'd2);
    ok = O_Req;
    if (!ok) do_reset();
  endtask

  task automatic scramble_ftk(input int own, input logic [N*FW-1:0] f);
    logic [N*FW-1:0] sm;
    sm    = (N*FW)'({FW{1'b1}}) << (own*FW);
    I_FTk = ((N*FW)'($urandom) & ~sm) | (f & sm);
  endtask

  // mode 0: ack then done; 1: withdraw in WAIT with ack; 2: withdraw in HOLD with done
  task automatic run_txn(input logic [N-1:0] mask, input int stall, input int hold, input int mode);
    int              own;
    logic [N*FW-1:0] f;
    bit              ok;
    start_txn(mask, own, f, ok);
    if (!ok) return;
    for (int i = 0; i < stall; i++) begin
      I_Ack   = 1'b1;
      I_Stall = 1'b1;
      I_Done  = 1'($urandom);
      scramble_ftk(own, f);
      step();
      chk("req_held_in_stall", 64'(O_Req), 64'd1);
      chk("busy_in_wait", 64'(O_Busy), 64'd1);
    end
    I_Done = 1'b0;
    if (mode == 1) begin
      I_Req[own] = 1'b0;
      I_Ack      = 1'b1;
      I_Stall    = 1'b0;
      step();
      chk("withdraw_wait_req", 64'(O_Req), 64'd0);
      chk("withdraw_wait_busy", 64'(O_Busy), 64'd0);
      chk("withdraw_wait_grant", 64'(O_Grant), 64'd0);
      chk("withdraw_wait_ftk", 64'(O_FTk), 64'd0);
    end else begin
      I_Ack   = 1'b1;
      I_Stall = 1'b0;
      step();
      I_Ack = 1'b0;
      chk("ack_drops_req", 64'(O_Req), 64'd0);
      chk("busy_in_hold", 64'(O_Busy), 64'd1);
      for (int i = 0; i < hold; i++) begin
        I_Ack = 1'($urandom);
        scramble_ftk(own, f);
        step();
        chk("hold_grant", 64'(O_Grant), 64'(1) << own);
        chk("hold_no_req", 64'(O_Req), 64'd0);
      end
      I_Ack  = 1'b0;
      I_Done = 1'b1;
      if (mode == 2) I_Req[own] = 1'b0;
      step();
      chk("end_busy", 64'(O_Busy), 64'd0);
      chk("end_grant", 64'(O_Grant), 64'd0);
      chk("end_ftk", 64'(O_FTk), 64'd0);
      chk("end_req", 64'(O_Req), 64'd0);
      if (mode == 0) model_ptr = (own + 1) % N;
    end
    idle_inputs();
    repeat ($urandom_range(1, 2)) step();
  endtask

  task automatic reset_mid(input logic [N-1:0] mask);
    int              own;
    logic [N*FW-1:0] f;
    bit              ok;
    start_txn(mask, own, f, ok);
    if (!ok) return;
    reset = 1'b1;
    step();
    chk("rst_mid_grant", 64'(O_Grant), 64'd0);
    chk("rst_mid_req", 64'(O_Req), 64'd0);
    chk("rst_mid_ftk", 64'(O_FTk), 64'd0);
    chk("rst_mid_busy", 64'(O_Busy), 64'd0);
    chk("rst_mid_owner", 64'(O_Owner), 64'd0);
    reset = 1'b0;
    idle_inputs();
    model_ptr = 0;
    step();
  endtask

  // Monitor: every new grant must match the next scoreboard entry.
  logic [N-1:0]  prev_g = '0;
  logic [FW-1:0] cur_ftk = '0;
  always @(negedge clock) begin : monitor
    exp_t e;
    chk("grant_onehot0", 64'($onehot0(O_Grant)), 64'd1);
    if (O_Grant != '0 && prev_g == '0) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant: got 0x%0h expected none at %0t", O_Grant, $time);
      end else begin
        e = q.pop_front();
        chk("grant_vec", 64'(O_Grant), 64'(1) << e.owner);
        chk("owner", 64'(O_Owner), 64'(e.owner));
        chk("grant_ftk", 64'(O_FTk), 64'(e.ftk));
        chk("grant_busy", 64'(O_Busy), 64'd1);
        cur_ftk = e.ftk;
      end
    end else if (O_Grant != '0) begin
      chk("grant_stable", 64'(O_Grant), 64'(prev_g));
      chk("ftk_stable", 64'(O_FTk), 64'(cur_ftk));
    end
    prev_g = O_Grant;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    I_FTk = '0;
    reset = 1'b1;
    step();
    step();
    chk("reset_grant", 64'(O_Grant), 64'd0);
    chk("reset_req", 64'(O_Req), 64'd0);
    chk("reset_ftk", 64'(O_FTk), 64'd0);
    chk("reset_busy", 64'(O_Busy), 64'd0);
    chk("reset_owner", 64'(O_Owner), 64'd0);
    reset = 1'b0;
    step();
    chk("idle_no_busy", 64'(O_Busy), 64'd0);

    run_txn(4'b0100, 0, 1, 0);
    run_txn(4'b0011, 0, 0, 0);
    run_txn(4'b1111, 3, 1, 0);
    run_txn(4'b1111, 0, 2, 0);
    run_txn(4'b1111, 1, 0, 0);
    run_txn(4'b1111, 0, 1, 0);
    run_txn(4'b1111, 2, 0, 0);
    run_txn(4'b0010, 0, 1, 2);
    run_txn(4'b1111, 0, 0, 0);
    run_txn(4'b1010, 1, 0, 1);
    reset_mid(4'b1000);
    run_txn(4'b1111, 0, 0, 0);

    for (int t = 0; t < 80; t++) begin
      int r;
      int mode;
      r    = int'($urandom_range(0, 9));
      mode = (r < 6) ? 0 : ((r < 8) ? 1 : 2);
      if ($urandom_range(0, 19) == 0) begin
        reset_mid(N'($urandom_range(1, 15)));
      end else begin
        run_txn(N'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), mode);
      end
    end

    step();
    step();
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
